// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter sharing one in-order DIR/DOR pipeline between NREQ requesters.
// A tag FIFO records the requester of each accepted item so that results are steered back to it.
module pipeline_arbiter #(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  pipe_dir,
    output logic [WIDTH-1:0]      pipe_data_in,
    input  logic                  pipe_in_ack,
    input  logic                  pipe_dor,
    input  logic [WIDTH-1:0]      pipe_data_out,
    output logic                  pipe_out_ack,
    output logic                  err_orphan
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {ISSUE_IDLE, ISSUE_WAIT} issue_state_t;
    typedef enum logic [1:0] {RET_IDLE, RET_HOLD, RET_ACK} ret_state_t;

    issue_state_t    issue_q, issue_d;
    ret_state_t      ret_q, ret_d;
    logic [ID_W-1:0] rr_q, rr_d, id_q, id_d;
    logic [NREQ-1:0] req_ack_d, rsp_valid_d, req_pending;
    logic [WIDTH-1:0] pipe_data_in_d, rsp_data_d;
    logic            pipe_dir_d, pipe_out_ack_d, err_orphan_d;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   scan_idx;

    logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [ID_W-1:0]  head_id;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_id = tag_mem[rd_ptr];

    // The requester acked this cycle still shows req_valid; mask it so it is not granted twice.
    always_comb begin
        req_pending = req_valid & ~req_ack;
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NREQ))
                scan_idx = scan_idx - (ID_W+1)'(NREQ);
            if (!grant_found && req_pending[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        issue_d        = issue_q;
        rr_d           = rr_q;
        id_d           = id_q;
        pipe_dir_d     = pipe_dir;
        pipe_data_in_d = pipe_data_in;
        req_ack_d      = '0;
        push           = 1'b0;
        case (issue_q)
            ISSUE_IDLE: begin
                if (grant_found && fifo_count < CNT_W'(MAX_INFLIGHT)) begin
                    id_d           = grant_id;
                    pipe_data_in_d = req_data[grant_id*WIDTH +: WIDTH];
                    pipe_dir_d     = 1'b1;
                    issue_d        = ISSUE_WAIT;
                end
            end
            ISSUE_WAIT: begin
                if (pipe_in_ack) begin
                    pipe_dir_d = 1'b0;
                    req_ack_d  = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
                    push       = 1'b1;
                    rr_d       = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    issue_d    = ISSUE_IDLE;
                end
            end
            default: issue_d = ISSUE_IDLE;
        endcase
    end

    always_comb begin
        ret_d          = ret_q;
        rsp_valid_d    = rsp_valid;
        rsp_data_d     = rsp_data;
        pipe_out_ack_d = 1'b0;
        err_orphan_d   = err_orphan;
        pop            = 1'b0;
        case (ret_q)
            RET_IDLE: begin
                if (pipe_dor) begin
                    if (fifo_count != '0) begin
                        rsp_data_d  = pipe_data_out;
                        rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << head_id;
                        ret_d       = RET_HOLD;
                    end else begin
                        err_orphan_d   = 1'b1;
                        pipe_out_ack_d = 1'b1;
                        ret_d          = RET_ACK;
                    end
                end
            end
            RET_HOLD: begin
                if (rsp_ready[head_id]) begin
                    rsp_valid_d    = '0;
                    pipe_out_ack_d = 1'b1;
                    pop            = 1'b1;
                    ret_d          = RET_ACK;
                end
            end
            RET_ACK: ret_d = RET_IDLE;
            default: ret_d = RET_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q      <= ISSUE_IDLE;
            ret_q        <= RET_IDLE;
            rr_q         <= '0;
            id_q         <= '0;
            req_ack      <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            pipe_dir     <= 1'b0;
            pipe_data_in <= '0;
            pipe_out_ack <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            issue_q      <= issue_d;
            ret_q        <= ret_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            req_ack      <= req_ack_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            pipe_dir     <= pipe_dir_d;
            pipe_data_in <= pipe_data_in_d;
            pipe_out_ack <= pipe_out_ack_d;
            err_orphan   <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter: the bench plays both the requesters and the pipeline.
module tb_pipeline_arbiter;

    localparam int NREQ         = 4;
    localparam int WIDTH        = 8;
    localparam int MAX_INFLIGHT = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [NREQ-1:0]       rsp_ready;
    logic                  pipe_dir;
    logic [WIDTH-1:0]      pipe_data_in;
    logic                  pipe_in_ack;
    logic                  pipe_dor;
    logic [WIDTH-1:0]      pipe_data_out;
    logic                  pipe_out_ack;
    logic                  err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ack(req_ack),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .pipe_dir(pipe_dir),
        .pipe_data_in(pipe_data_in),
        .pipe_in_ack(pipe_in_ack),
        .pipe_dor(pipe_dor),
        .pipe_data_out(pipe_data_out),
        .pipe_out_ack(pipe_out_ack),
        .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic set_req(input int i, input logic [WIDTH-1:0] d);
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid   = '0;
        pipe_in_ack = 1'b0;
        pipe_dor    = 1'b0;
        rsp_ready   = '0;
        step();
        reset = 1'b0;
    endtask

    // Pipeline side: wait for pipe_dir, check the offered data, accept it, expect the req_ack pulse.
    task automatic issue(input int id, input logic [WIDTH-1:0] d);
        int n = 0;
        while (pipe_dir !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("issue_dir", pipe_dir, 1);
        check("issue_data", pipe_data_in, d);
        check("issue_noack", req_ack, 0);
        pipe_in_ack = 1'b1;
        step();
        pipe_in_ack = 1'b0;
        check("issue_ack", req_ack, oh(id));
        check("issue_dir_low", pipe_dir, 0);
    endtask

    // Pipeline presents a result; the expected requester accepts it straight away.
    task automatic ret(input int id, input logic [WIDTH-1:0] d);
        int n = 0;
        pipe_dor      = 1'b1;
        pipe_data_out = d;
        rsp_ready     = oh(id);
        while (rsp_valid === '0 && n < 20) begin
            step();
            n++;
        end
        check("ret_valid", rsp_valid, oh(id));
        check("ret_data", rsp_data, d);
        step();
        check("ret_ack", pipe_out_ack, 1);
        check("ret_drop", rsp_valid, 0);
        pipe_dor  = 1'b0;
        rsp_ready = '0;
        step();
        check("ret_ack_low", pipe_out_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stable;
        int   n;
        req_data      = '0;
        pipe_data_out = '0;
        reset         = 1'b1;
        req_valid     = '0;
        pipe_in_ack   = 1'b0;
        pipe_dor      = 1'b0;
        rsp_ready     = '0;
        step();
        step();
        check("rst_req_ack", req_ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_pipe_dir", pipe_dir, 0);
        check("rst_pipe_data_in", pipe_data_in, 0);
        check("rst_out_ack", pipe_out_ack, 0);
        check("rst_orphan", err_orphan, 0);
        reset = 1'b0;

        // single request from requester 0
        set_req(0, 8'd42);
        req_valid = 4'b0001;
        step();
        check("t1_dir_latency", pipe_dir, 1);
        issue(0, 8'd42);
        req_valid = '0;
        step();
        check("t1_ack_once", req_ack, 0);
        check("t1_no_regrant", pipe_dir, 0);
        ret(0, 8'hA5);

        // round robin with all requesters held, then FIFO-full stall
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(8'h10 + i));
        req_valid = 4'b1111;
        issue(0, 8'h10);
        issue(1, 8'h11);
        issue(2, 8'h12);
        issue(3, 8'h13);
        stable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (pipe_dir !== 1'b0 || req_ack !== '0) stable = 1'b0;
        end
        check("t3_full_stall", stable, 1);
        ret(0, 8'hC0);
        issue(0, 8'h10);
        req_valid = '0;
        ret(1, 8'hC1);
        ret(2, 8'hC2);
        ret(3, 8'hC3);
        ret(0, 8'hC4);
        check("t2_idle_after", pipe_dir, 0);

        // backpressure; rsp_ready of other requesters must be ignored
        do_reset();
        set_req(2, 8'h77);
        req_valid = 4'b0100;
        issue(2, 8'h77);
        req_valid     = '0;
        pipe_dor      = 1'b1;
        pipe_data_out = 8'h3C;
        rsp_ready     = 4'b1011;
        n = 0;
        while (rsp_valid === '0 && n < 20) begin
            step();
            n++;
        end
        pipe_data_out = 8'hFF;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rsp_valid !== 4'b0100 || rsp_data !== 8'h3C || pipe_out_ack !== 1'b0) stable = 1'b0;
        end
        check("t4_stable", stable, 1);
        check("t4_valid", rsp_valid, 4'b0100);
        rsp_ready = 4'b0100;
        step();
        check("t4_ack", pipe_out_ack, 1);
        check("t4_drop", rsp_valid, 0);
        pipe_dor  = 1'b0;
        rsp_ready = '0;
        step();
        check("t4_ack_pulse", pipe_out_ack, 0);

        // ordering: requester 2 then requester 0
        do_reset();
        set_req(2, 8'h22);
        req_valid = 4'b0100;
        issue(2, 8'h22);
        set_req(0, 8'h11);
        req_valid = 4'b0001;
        issue(0, 8'h11);
        req_valid = '0;
        ret(2, 8'hB2);
        ret(0, 8'hB0);

        // orphan result, then reset in the middle of a held response
        do_reset();
        pipe_dor      = 1'b1;
        pipe_data_out = 8'hEE;
        step();
        check("t6_orphan", err_orphan, 1);
        check("t6_drain_ack", pipe_out_ack, 1);
        check("t6_no_rsp", rsp_valid, 0);
        pipe_dor = 1'b0;
        step();
        check("t6_ack_pulse", pipe_out_ack, 0);
        check("t6_sticky", err_orphan, 1);
        set_req(1, 8'h31);
        req_valid = 4'b0010;
        issue(1, 8'h31);
        req_valid     = '0;
        pipe_dor      = 1'b1;
        pipe_data_out = 8'h99;
        rsp_ready     = '0;
        step();
        check("t6_hold", rsp_valid, 4'b0010);
        reset = 1'b1;
        step();
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_data", rsp_data, 0);
        check("t6_rst_orphan", err_orphan, 0);
        check("t6_rst_out_ack", pipe_out_ack, 0);
        check("t6_rst_dir", pipe_dir, 0);
        check("t6_rst_req_ack", req_ack, 0);
        reset    = 1'b0;
        pipe_dor = 1'b0;
        step();
        check("t6_post_valid", rsp_valid, 0);
        check("t6_post_dir", pipe_dir, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
